// File: rtl/imem_program_encoder.sv
// rtl/imem_program_encoder.sv - encodes instruction requests into MIPS words and writes them to instruction memory
// Two-entry buffer between the request stream and the memory write port.
module imem_program_encoder #(
  parameter int ADDR_WIDTH = 9,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  finish,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_kind,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [5:0]            in_funct,
  input  logic [15:0]           in_imm,
  output logic                  imem_we,
  input  logic                  imem_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_eom;
  logic                  r_err;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH-1:0] r_buf_addr [BUF_DEPTH];
  logic [31:0]           r_buf_data [BUF_DEPTH];
  logic                  r_head;
  logic                  r_tail;
  logic [1:0]            r_occ;

  logic        w_full;
  logic        w_accept;
  logic        w_legal;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_word;

  always_comb begin
    w_word  = 32'hFC00_0000;
    w_legal = 1'b1;
    case (in_kind)
      3'd0:    w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, in_funct};
      3'd1:    w_word = {6'b100011, in_rs, in_rt, in_imm};
      3'd2:    w_word = {6'b101011, in_rs, in_rt, in_imm};
      3'd3:    w_word = {6'b000100, in_rs, in_rt, in_imm};
      3'd4:    w_word = 32'hFC00_0000;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_full   = (r_occ == 2'(BUF_DEPTH));
  assign in_ready = (r_state == S_LOAD) && !w_full && !r_eom;
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_legal;
  assign imem_we  = (r_occ != 2'd0);
  assign w_pop    = imem_we && imem_ready;

  assign imem_addr  = imem_we ? r_buf_addr[r_head] : '0;
  assign imem_wdata = imem_we ? r_buf_data[r_head] : '0;
  assign done       = (r_state == S_DRAIN) && (r_occ == 2'd0);
  assign count      = r_count;
  assign err        = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_eom   <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_occ   <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_addr[i] <= '0;
        r_buf_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_buf_addr[r_tail] <= r_ptr;
        r_buf_data[r_tail] <= w_word;
        r_tail             <= ~r_tail;
      end
      if (w_pop) begin
        r_head  <= ~r_head;
        r_count <= r_count + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ptr   <= start_addr;
            r_count <= '0;
            r_err   <= 1'b0;
            r_eom   <= 1'b0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // The last word address latches the end-of-memory flag instead of wrapping.
          if (w_push) begin
            if (r_ptr == {ADDR_WIDTH{1'b1}}) r_eom <= 1'b1;
            else                             r_ptr <= r_ptr + 1'b1;
          end
          if ((w_accept && !w_legal) || (in_valid && r_eom)) r_err <= 1'b1;
          if (finish) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_occ == 2'd0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_encoder.sv
// tb/tb_imem_program_encoder.sv - directed and randomized checks of imem_program_encoder against a word-queue model
module tb_imem_program_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  start_addr = '0;
  logic        finish = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_kind = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic        imem_we;
  logic        imem_ready = 1'b1;
  logic [8:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        done;
  logic [9:0]  count;
  logic        err;

  int total = 0;
  int bad = 0;
  int m_ptr = 0;
  int m_count = 0;
  int done_cnt = 0;
  bit rnd_ready = 0;
  logic [40:0] exp_q[$];

  imem_program_encoder #(.ADDR_WIDTH(9), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm), .imem_we(imem_we), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .done(done), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_word(input int kind, input int rs, input int rt,
                                             input int rd, input int funct, input int imm);
    logic [31:0] op;
    case (kind)
      0: return rs * 32'd2097152 + rt * 32'd65536 + rd * 32'd2048 + funct;
      1: op = 32'd35;
      2: op = 32'd43;
      3: op = 32'd4;
      default: return 32'hFC000000;
    endcase
    return op * 32'd67108864 + rs * 32'd2097152 + rt * 32'd65536 + imm;
  endfunction

  // Scoreboard: every committed write must match the next expected word.
  always @(negedge clk) begin
    if (!reset && imem_we && imem_ready) begin
      if (exp_q.size() == 0) chk("unexpected_write", {23'd0, imem_addr, imem_wdata}, 64'h0);
      else begin
        chk("commit_word", {23'd0, imem_addr, imem_wdata}, {23'd0, exp_q[0]});
        void'(exp_q.pop_front());
      end
      m_count++;
    end
    if (!reset && done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int addr);
    start_addr = 9'(addr);
    start = 1'b1;
    tick();
    start = 1'b0;
    m_ptr = addr;
    m_count = 0;
  endtask

  task automatic push(input int kind, input int rs, input int rt, input int rd, input int funct,
                      input int imm, input int max_wait, output bit accepted);
    in_valid = 1'b1;
    in_kind = 3'(kind); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_funct = 6'(funct); in_imm = 16'(imm);
    accepted = 0;
    for (int i = 0; i < max_wait; i++) begin
      if (rnd_ready) imem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        accepted = 1;
        if (kind <= 4) begin
          exp_q.push_back({9'(m_ptr), model_word(kind, rs, rt, rd, funct, imm)});
          m_ptr++;
        end
      end
      tick();
      if (accepted) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic push_ok(input int kind, input int rs, input int rt, input int rd,
                         input int funct, input int imm);
    bit acc;
    push(kind, rs, rt, rd, funct, imm, 40, acc);
    chk("push_accepted", 64'(acc), 64'd1);
  endtask

  task automatic finish_and_wait(input int exp_count);
    bit seen;
    int d0;
    imem_ready = 1'b1;
    rnd_ready = 0;
    d0 = done_cnt;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (done_cnt != d0) begin seen = 1; break; end
      tick();
    end
    repeat (3) tick();
    chk("done_seen", 64'(seen), 64'd1);
    chk("done_single_pulse", 64'(done_cnt - d0), 64'd1);
    chk("count_final", 64'(count), 64'(exp_count));
    chk("model_count", 64'(m_count), 64'(exp_count));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit acc;
    int n;
    int d0;
    logic [31:0] first_word;

    // Reset state, even with a request waiting.
    in_valid = 1'b1;
    repeat (2) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_imem_we", 64'(imem_we), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_addr_data", {23'd0, imem_addr, imem_wdata}, 64'd0);
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_no_write", 64'(imem_we), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;

    // Directed encodings with first-word latency.
    do_start(9'h010);
    push_ok(0, 1, 2, 3, 6'h20, 0);
    chk("rtype_addr", 64'(imem_addr), 64'h010);
    chk("rtype_word", 64'(imem_wdata), 64'h00221820);
    push_ok(1, 29, 8, 0, 0, 16'h0004);
    chk("lw_addr", 64'(imem_addr), 64'h011);
    chk("lw_word", 64'(imem_wdata), 64'h8FA80004);
    push_ok(2, 29, 8, 0, 0, 16'hFFFC);
    chk("sw_word", 64'(imem_wdata), 64'hAFA8FFFC);
    push_ok(3, 4, 5, 0, 0, 16'hFFFF);
    chk("beq_word", 64'(imem_wdata), 64'h1085FFFF);
    push_ok(4, 7, 7, 7, 7, 16'h1234);
    chk("nop_word", 64'(imem_wdata), 64'hFC000000);
    finish_and_wait(5);

    // Backpressure: two words buffered, third held off until the memory drains.
    do_start(9'h040);
    imem_ready = 1'b0;
    first_word = model_word(1, 3, 4, 0, 0, 16'h0100);
    push_ok(1, 3, 4, 0, 0, 16'h0100);
    push_ok(2, 5, 6, 0, 0, 16'h0200);
    in_valid = 1'b1;
    in_kind = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_addr_stable", 64'(imem_addr), 64'h040);
      chk("bp_data_stable", 64'(imem_wdata), 64'(first_word));
    end
    in_valid = 1'b0;
    imem_ready = 1'b1;
    tick();
    chk("bp_commit1", 64'(count), 64'd1);
    tick();
    chk("bp_commit2", 64'(count), 64'd2);
    push_ok(0, 9, 10, 11, 6'h22, 0);
    finish_and_wait(3);

    // Randomized program with random memory backpressure.
    n = 40;
    do_start($urandom_range(0, 400));
    rnd_ready = 1;
    for (int i = 0; i < n; i++) begin
      push_ok($urandom_range(0, 4), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535));
      repeat ($urandom_range(0, 2)) begin
        imem_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    chk("rand_err_clear", 64'(err), 64'd0);
    finish_and_wait(n);

    // End of memory: no wrap, further valid requests flag an error.
    do_start(9'h1FE);
    push_ok(0, 1, 1, 1, 1, 0);
    push_ok(1, 2, 2, 0, 0, 16'h0008);
    push(3, 1, 2, 0, 0, 16'h0010, 4, acc);
    chk("eom_blocked", 64'(acc), 64'd0);
    chk("eom_in_ready", 64'(in_ready), 64'd0);
    chk("eom_err", 64'(err), 64'd1);
    finish_and_wait(2);
    chk("err_sticky", 64'(err), 64'd1);

    // Illegal kind, then reset during drain.
    do_start(9'h080);
    chk("start_clears_err", 64'(err), 64'd0);
    push(6, 1, 2, 3, 4, 5, 10, acc);
    chk("illegal_accepted", 64'(acc), 64'd1);
    tick();
    chk("illegal_err", 64'(err), 64'd1);
    chk("illegal_no_write", 64'(imem_we), 64'd0);
    chk("illegal_count", 64'(count), 64'd0);
    imem_ready = 1'b0;
    push_ok(0, 1, 2, 3, 6'h20, 0);
    push_ok(1, 1, 2, 0, 0, 16'h0004);
    chk("illegal_ptr_kept", 64'(imem_addr), 64'h080);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("mid_rst_we", 64'(imem_we), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    imem_ready = 1'b1;
    repeat (4) tick();
    chk("post_rst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("post_rst_no_write", 64'(imem_we), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
